vid_out_ctrl_regs: RTL and testbench

- Next-generation Avalon-MM control/status block for the clocked-video output path. It sits between the host CPU and the ImageStream-to-video output engine.
- Holds enable, genlock and interrupt-enable control, plus status and interrupt registers. Reports FIFO level, matched mode and a priority-encoded mode index.
- Forwards mode-bank writes through a one-shot trigger/ack handshake with timeout.
- Generalises the previous control block: parametrised data width and mode count, registered reads, FIFO-threshold interrupt, timeout protection.

---
 rtl/vid_out_ctrl_pkg.sv | 37 +++
 rtl/vid_mode_prio_enc.sv | 24 ++
 rtl/vid_out_ctrl_regs.sv | 226 ++++++++++++++++++++++
 tb/tb_vid_out_ctrl_regs.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_out_ctrl_pkg.sv
// Shared register map, bit positions and forwarding FSM states for the
// clocked-video output control block.
package vid_out_ctrl_pkg;

  localparam logic [7:0] ADDR_CTRL       = 8'd0;
  localparam logic [7:0] ADDR_STATUS     = 8'd1;
  localparam logic [7:0] ADDR_IRQ        = 8'd2;
  localparam logic [7:0] ADDR_USEDW      = 8'd3;
  localparam logic [7:0] ADDR_MODE_MATCH = 8'd4;
  localparam logic [7:0] ADDR_MODE_IDX   = 8'd5;
  localparam logic [7:0] ADDR_THRESH     = 8'd6;
  localparam logic [7:0] ADDR_UFCNT      = 8'd7;
  localparam logic [7:0] MODE_BANK_BASE  = 8'd8;

  localparam int unsigned CTRL_EN         = 0;
  localparam int unsigned CTRL_IE_MODE    = 1;
  localparam int unsigned CTRL_IE_GENLOCK = 2;
  localparam int unsigned CTRL_IE_THRESH  = 3;
  localparam int unsigned CTRL_GL_LO      = 4;
  localparam int unsigned CTRL_GL_HI      = 5;

  localparam int unsigned ST_RESYNC    = 0;
  localparam int unsigned ST_UNDERFLOW = 2;
  localparam int unsigned ST_GENLOCKED = 3;
  localparam int unsigned ST_TIMEOUT   = 4;

  localparam int unsigned IRQ_MODE    = 1;
  localparam int unsigned IRQ_GENLOCK = 2;
  localparam int unsigned IRQ_THRESH  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } fwd_state_t;

endpackage

// File: rtl/vid_mode_prio_enc.sv
// Lowest-set-bit encoder for the latched mode-match vector.
module vid_mode_prio_enc
  import vid_out_ctrl_pkg::*;
#(
  parameter int unsigned NO_OF_MODES = 4,
  parameter int unsigned IDX_W       = 2
) (
  input  logic [NO_OF_MODES-1:0] vec,
  output logic [IDX_W-1:0]       idx,
  output logic                   valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < NO_OF_MODES; i++) begin
      if (vec[i] && !valid) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vid_out_ctrl_regs.sv
// Avalon-MM control/status registers for the clocked-video output path.
// Optional underflow event counter at address 7: define UNDERFLOW_COUNT_EN.
module vid_out_ctrl_regs
  import vid_out_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned NO_OF_MODES      = 4,
  parameter int unsigned USED_WORDS_WIDTH = 15,
  parameter int unsigned ACK_TIMEOUT      = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mode_change,
  input  logic [NO_OF_MODES-1:0]      mode_match,
  input  logic                        mode_write_ack,
  input  logic [USED_WORDS_WIDTH-1:0] usedw,
  input  logic                        underflow_sticky,
  input  logic                        enable_resync,
  input  logic                        genlocked,
  output logic                        enable,
  output logic [1:0]                  genlock_enable,
  output logic                        clear_underflow_sticky,
  output logic                        write_trigger,
  input  logic [7:0]                  av_address,
  input  logic                        av_read,
  input  logic                        av_write,
  input  logic [DATA_WIDTH-1:0]       av_writedata,
  output logic [DATA_WIDTH-1:0]       av_readdata,
  output logic                        av_readdatavalid,
  output logic                        av_waitrequest,
  output logic                        irq
);

  localparam int unsigned IDX_W = (NO_OF_MODES > 1) ? $clog2(NO_OF_MODES) : 1;
  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  logic                        en_q, ie_mode_q, ie_genlock_q, ie_thresh_q;
  logic [1:0]                  gl_en_q;
  logic [3:1]                  pend_q, irq_set, ie_vec, w1c;
  logic                        timeout_q, clr_uf_q, genlocked_d;
  logic [NO_OF_MODES-1:0]      mm_q;
  logic [USED_WORDS_WIDTH-1:0] thresh_q, usedw_d;
  logic [IDX_W-1:0]            enc_idx;
  logic                        enc_valid;
  logic [DATA_WIDTH-1:0]       rd_mux;
  fwd_state_t                  state_q, state_d;
  logic [CNT_W-1:0]            cnt_q;
  logic                        load_cnt, expire;
  logic                        wr_lo, wr_hi, wr_ctrl, wr_status, wr_irq, wr_thresh;
  logic                        unused_ok;

  assign wr_lo     = av_write && (av_address < MODE_BANK_BASE);
  assign wr_hi     = av_write && (av_address >= MODE_BANK_BASE);
  assign wr_ctrl   = wr_lo && (av_address == ADDR_CTRL);
  assign wr_status = wr_lo && (av_address == ADDR_STATUS);
  assign wr_irq    = wr_lo && (av_address == ADDR_IRQ);
  assign wr_thresh = wr_lo && (av_address == ADDR_THRESH);
  assign unused_ok = &{1'b0, av_writedata};

  // Interrupt sources; pending bits are masked by their enables every cycle
  always_comb begin
    irq_set              = '0;
    ie_vec               = '0;
    irq_set[IRQ_MODE]    = ie_mode_q && mode_change;
    irq_set[IRQ_GENLOCK] = ie_genlock_q && (genlocked != genlocked_d);
    irq_set[IRQ_THRESH]  = ie_thresh_q && (usedw < thresh_q) && (usedw_d >= thresh_q);
    ie_vec[IRQ_MODE]     = ie_mode_q;
    ie_vec[IRQ_GENLOCK]  = ie_genlock_q;
    ie_vec[IRQ_THRESH]   = ie_thresh_q;
    w1c                  = wr_irq ? av_writedata[IRQ_THRESH:IRQ_MODE] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q         <= 1'b0;
      ie_mode_q    <= 1'b0;
      ie_genlock_q <= 1'b0;
      ie_thresh_q  <= 1'b0;
      gl_en_q      <= '0;
      pend_q       <= '0;
      timeout_q    <= 1'b0;
      clr_uf_q     <= 1'b0;
      genlocked_d  <= 1'b0;
      usedw_d      <= '0;
      thresh_q     <= '0;
      mm_q         <= '0;
    end else begin
      genlocked_d <= genlocked;
      usedw_d     <= usedw;
      pend_q      <= ((pend_q & ~w1c) | irq_set) & ie_vec;
      if (mode_change) mm_q <= mode_match;
      if (wr_ctrl) begin
        en_q         <= av_writedata[CTRL_EN];
        ie_mode_q    <= av_writedata[CTRL_IE_MODE];
        ie_genlock_q <= av_writedata[CTRL_IE_GENLOCK];
        ie_thresh_q  <= av_writedata[CTRL_IE_THRESH];
        gl_en_q      <= av_writedata[CTRL_GL_HI:CTRL_GL_LO];
      end
      if (wr_thresh) thresh_q <= USED_WORDS_WIDTH'(av_writedata);
      if (expire) timeout_q <= 1'b1;
      else if (wr_status && av_writedata[ST_TIMEOUT]) timeout_q <= 1'b0;
      if (wr_status && av_writedata[ST_UNDERFLOW]) clr_uf_q <= 1'b1;
      else if (!underflow_sticky) clr_uf_q <= 1'b0;
    end
  end

`ifdef UNDERFLOW_COUNT_EN
  logic        uf_d;
  logic        uf_rise;
  logic [15:0] ufcnt_q;

  assign uf_rise = underflow_sticky && !uf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uf_d    <= 1'b0;
      ufcnt_q <= '0;
    end else begin
      uf_d <= underflow_sticky;
      // Clearing write and a coincident edge leave exactly that one edge counted
      if (wr_lo && (av_address == ADDR_UFCNT)) ufcnt_q <= {15'd0, uf_rise};
      else if (uf_rise && (ufcnt_q != '1)) ufcnt_q <= ufcnt_q + 16'd1;
    end
  end
`endif

  vid_mode_prio_enc #(
    .NO_OF_MODES(NO_OF_MODES),
    .IDX_W      (IDX_W)
  ) u_prio_enc (
    .vec  (mm_q),
    .idx  (enc_idx),
    .valid(enc_valid)
  );

  // Mode-bank forwarding: waitrequest is raised combinationally in IDLE so the
  // host holds the first strobe until the mode bank answers or time runs out.
  always_comb begin
    state_d        = state_q;
    write_trigger  = 1'b0;
    av_waitrequest = 1'b0;
    load_cnt       = 1'b0;
    expire         = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_hi) begin
          write_trigger  = 1'b1;
          av_waitrequest = 1'b1;
          load_cnt       = 1'b1;
          state_d        = WAIT;
        end
      end
      WAIT: begin
        av_waitrequest = 1'b1;
        if (mode_write_ack) begin
          state_d = DONE;
        end else if (cnt_q == '0) begin
          expire  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_cnt) cnt_q <= CNT_W'(ACK_TIMEOUT);
      else if ((state_q == WAIT) && (cnt_q != '0)) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (av_address)
      ADDR_CTRL: begin
        rd_mux[CTRL_EN]               = en_q;
        rd_mux[CTRL_IE_MODE]          = ie_mode_q;
        rd_mux[CTRL_IE_GENLOCK]       = ie_genlock_q;
        rd_mux[CTRL_IE_THRESH]        = ie_thresh_q;
        rd_mux[CTRL_GL_HI:CTRL_GL_LO] = gl_en_q;
      end
      ADDR_STATUS: begin
        rd_mux[ST_RESYNC]    = enable_resync;
        rd_mux[ST_UNDERFLOW] = underflow_sticky;
        rd_mux[ST_GENLOCKED] = genlocked;
        rd_mux[ST_TIMEOUT]   = timeout_q;
      end
      ADDR_IRQ:        rd_mux[IRQ_THRESH:IRQ_MODE] = pend_q;
      ADDR_USEDW:      rd_mux = DATA_WIDTH'(usedw);
      ADDR_MODE_MATCH: rd_mux = DATA_WIDTH'(mm_q);
      ADDR_MODE_IDX: begin
        rd_mux[IDX_W-1:0]      = enc_idx;
        rd_mux[DATA_WIDTH-1]   = enc_valid;
      end
      ADDR_THRESH:     rd_mux = DATA_WIDTH'(thresh_q);
`ifdef UNDERFLOW_COUNT_EN
      ADDR_UFCNT:      rd_mux = DATA_WIDTH'(ufcnt_q);
`else
      ADDR_UFCNT:      rd_mux = '0;
`endif
      default:         rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      av_readdata      <= '0;
      av_readdatavalid <= 1'b0;
    end else begin
      av_readdatavalid <= av_read;
      if (av_read) av_readdata <= rd_mux;
    end
  end

  assign enable                 = en_q;
  assign genlock_enable         = gl_en_q;
  assign clear_underflow_sticky = clr_uf_q;
  assign irq                    = |pend_q;

endmodule

// File: tb/tb_vid_out_ctrl_regs.sv
// Self-checking bench for vid_out_ctrl_regs: directed scenarios plus
// randomized traffic against a register-level reference model.
module tb_vid_out_ctrl_regs;

  localparam int unsigned DW = 32;
  localparam int unsigned NM = 4;
  localparam int unsigned UW = 15;
  localparam int unsigned TO = 8;

  logic          clk, rst_n;
  logic          mode_change, mode_write_ack, underflow_sticky, enable_resync, genlocked;
  logic [NM-1:0] mode_match;
  logic [UW-1:0] usedw;
  logic          enable, clear_underflow_sticky, write_trigger;
  logic [1:0]    genlock_enable;
  logic [7:0]    av_address;
  logic          av_read, av_write, av_readdatavalid, av_waitrequest, irq;
  logic [DW-1:0] av_writedata, av_readdata;

  vid_out_ctrl_regs #(
    .DATA_WIDTH      (DW),
    .NO_OF_MODES     (NM),
    .USED_WORDS_WIDTH(UW),
    .ACK_TIMEOUT     (TO)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .mode_change           (mode_change),
    .mode_match            (mode_match),
    .mode_write_ack        (mode_write_ack),
    .usedw                 (usedw),
    .underflow_sticky      (underflow_sticky),
    .enable_resync         (enable_resync),
    .genlocked             (genlocked),
    .enable                (enable),
    .genlock_enable        (genlock_enable),
    .clear_underflow_sticky(clear_underflow_sticky),
    .write_trigger         (write_trigger),
    .av_address            (av_address),
    .av_read               (av_read),
    .av_write              (av_write),
    .av_writedata          (av_writedata),
    .av_readdata           (av_readdata),
    .av_readdatavalid      (av_readdatavalid),
    .av_waitrequest        (av_waitrequest),
    .irq                   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state, in register-map terms
  bit        m_en, m_iem, m_ieg, m_iet, m_to, m_clr, m_rdv;
  bit [1:0]  m_gl;
  bit [3:1]  m_pend;
  bit [3:0]  m_mm;
  int        m_thresh, m_prev_usedw, m_ufcnt;
  bit        m_prev_gl, m_prev_uf;
  bit [31:0] m_rd;
  logic      s_wreq, s_trig;

  task automatic model_reset();
    m_en = 0; m_iem = 0; m_ieg = 0; m_iet = 0; m_to = 0; m_clr = 0; m_rdv = 0;
    m_gl = 0; m_pend = 0; m_mm = 0; m_thresh = 0; m_prev_usedw = 0; m_ufcnt = 0;
    m_prev_gl = 0; m_prev_uf = 0; m_rd = 0;
  endtask

  function automatic bit [31:0] model_read(input int a);
    bit [31:0] r;
    r = 0;
    case (a)
      0: r = {26'd0, m_gl, m_iet, m_ieg, m_iem, m_en};
      1: r = {27'd0, m_to, genlocked, underflow_sticky, 1'b0, enable_resync};
      2: r = {28'd0, m_pend, 1'b0};
      3: r = 32'(usedw);
      4: r = 32'(m_mm);
      5: begin
        for (int i = 3; i >= 0; i--) if (m_mm[i]) r = 32'h8000_0000 | 32'(i);
      end
      6: r = 32'(m_thresh);
`ifdef UNDERFLOW_COUNT_EN
      7: r = 32'(m_ufcnt);
`endif
      default: r = 0;
    endcase
    return r;
  endfunction

  // Advance the model by one clock using the inputs currently applied
  task automatic model_update();
    bit [3:1] set, keep;
    bit       wr, uf_rise;
    int       a;
    a  = int'(av_address);
    wr = av_write && (a < 8);
    m_rdv = av_read;
    if (av_read) m_rd = model_read(a);
    set = 0;
    if (m_iem && mode_change) set[1] = 1;
    if (m_ieg && (genlocked != m_prev_gl)) set[2] = 1;
    if (m_iet && (int'(usedw) < m_thresh) && (m_prev_usedw >= m_thresh)) set[3] = 1;
    keep = m_pend;
    if (wr && a == 2) keep = keep & ~av_writedata[3:1];
    m_pend = (keep | set) & {m_iet, m_ieg, m_iem};
    if (mode_change) m_mm = mode_match;
    if (wr && a == 0) begin
      m_en = av_writedata[0]; m_iem = av_writedata[1]; m_ieg = av_writedata[2];
      m_iet = av_writedata[3]; m_gl = av_writedata[5:4];
    end
    if (wr && a == 6) m_thresh = int'(av_writedata & 32'h7FFF);
    if (wr && a == 1 && av_writedata[4]) m_to = 0;
    if (wr && a == 1 && av_writedata[2]) m_clr = 1;
    else if (!underflow_sticky) m_clr = 0;
    uf_rise = underflow_sticky && !m_prev_uf;
    if (wr && a == 7) m_ufcnt = uf_rise ? 1 : 0;
    else if (uf_rise && m_ufcnt < 65535) m_ufcnt++;
    m_prev_gl    = genlocked;
    m_prev_usedw = int'(usedw);
    m_prev_uf    = underflow_sticky;
  endtask

  task automatic check_outputs();
    check_eq("enable", enable, m_en);
    check_eq("genlock_enable", genlock_enable, m_gl);
    check_eq("irq", irq, |m_pend);
    check_eq("clear_uf", clear_underflow_sticky, m_clr);
    check_eq("rdvalid", av_readdatavalid, m_rdv);
    if (m_rdv) check_eq("readdata", av_readdata, m_rd);
  endtask

  task automatic step();
    @(negedge clk);
    s_wreq = av_waitrequest;
    s_trig = write_trigger;
    model_update();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic wr_reg(input int a, input logic [31:0] d);
    av_write = 1; av_address = 8'(a); av_writedata = d;
    step();
    av_write = 0;
  endtask

  task automatic rd_reg(input int a, output logic [31:0] d);
    av_read = 1; av_address = 8'(a);
    step();
    av_read = 0;
    d = av_readdata;
  endtask

  // Mode-bank write; ack_at = cycle index (strobe cycle is 0) of a one-cycle ack, 0 = never
  task automatic bank_write(input int ack_at, output int hi, output int trig, output bit done);
    int c;
    av_write = 1; av_address = 8'h10; av_writedata = 32'hCAFE_0001;
    c = 0; hi = 0; trig = 0; done = 0;
    while (!done && c < 40) begin
      step();
      c++;
      if (s_wreq) hi++;
      if (s_trig) trig++;
      if (!s_wreq) begin
        done = 1;
        av_write = 0;
      end
      mode_write_ack = (ack_at != 0) && (c == ack_at);
    end
    mode_write_ack = 0;
    av_write = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int hi, trig;
    bit done;

    rst_n = 0; mode_change = 0; mode_match = 0; mode_write_ack = 0; usedw = 0;
    underflow_sticky = 0; enable_resync = 0; genlocked = 0;
    av_address = 0; av_read = 0; av_write = 0; av_writedata = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_enable", enable, 0);
    check_eq("rst_gl_en", genlock_enable, 0);
    check_eq("rst_irq", irq, 0);
    check_eq("rst_rdv", av_readdatavalid, 0);
    check_eq("rst_rdata", av_readdata, 0);
    check_eq("rst_trigger", write_trigger, 0);
    check_eq("rst_waitreq", av_waitrequest, 0);
    check_eq("rst_clr_uf", clear_underflow_sticky, 0);
    rst_n = 1;

    // CTRL write/readback
    wr_reg(0, 32'h3F);
    check_eq("ctrl_enable", enable, 1);
    check_eq("ctrl_gl_en", genlock_enable, 2'b11);
    rd_reg(0, d);
    check_eq("ctrl_read", d, 32'h3F);

    // Mode-change interrupt and latched match vector
    wr_reg(0, 32'h03);
    mode_match = 4'b0110; mode_change = 1;
    step();
    mode_change = 0;
    check_eq("mode_irq", irq, 1);
    rd_reg(2, d);
    check_eq("mode_pend", d, 32'h2);
    rd_reg(4, d);
    check_eq("mode_match", d, 32'h6);
    rd_reg(5, d);
    check_eq("mode_idx", d, 32'h8000_0001);
    wr_reg(2, 32'h2);
    check_eq("mode_w1c", irq, 0);

    // FIFO threshold crossing downward
    wr_reg(6, 32'd100);
    wr_reg(0, 32'h09);
    usedw = 100;
    step(); step();
    usedw = 99;
    step();
    check_eq("thresh_irq", irq, 1);
    rd_reg(2, d);
    check_eq("thresh_pend", d, 32'h8);
    wr_reg(2, 32'h8);
    repeat (3) step();
    check_eq("thresh_no_reset", irq, 0);

    // Forwarded write acknowledged after 5 cycles
    bank_write(5, hi, trig, done);
    check_eq("ack_done", done, 1);
    check_eq("ack_wait_cycles", hi, 6);
    check_eq("ack_trig_count", trig, 1);
    rd_reg(1, d);
    check_eq("ack_no_timeout", d[4], 0);

    // Forwarded write never acknowledged
    bank_write(0, hi, trig, done);
    m_to = 1;
    check_eq("to_done", done, 1);
    check_eq("to_wait_len", (hi >= int'(TO)) && (hi <= int'(TO) + 3), 1);
    check_eq("to_trig_count", trig, 1);
    rd_reg(1, d);
    check_eq("to_sticky", d[4], 1);
    wr_reg(1, 32'h10);
    rd_reg(1, d);
    check_eq("to_w1c", d[4], 0);

    // Stray ack while idle
    mode_write_ack = 1;
    step();
    mode_write_ack = 0;
    check_eq("idle_ack_wreq", s_wreq, 0);
    check_eq("idle_ack_trig", s_trig, 0);
    bank_write(2, hi, trig, done);
    check_eq("post_idle_ack_wait", hi, 3);

    // Mode-bank reads return 0 and never stall
    rd_reg(8'h80, d);
    check_eq("bank_read", d, 0);
    check_eq("bank_read_wreq", s_wreq, 0);

    // Underflow edges and clear request
    repeat (3) begin
      underflow_sticky = 1; step();
      underflow_sticky = 0; step();
    end
    rd_reg(7, d);
`ifdef UNDERFLOW_COUNT_EN
    check_eq("ufcnt", d, 32'd3);
`else
    check_eq("ufcnt", d, 32'd0);
`endif
    wr_reg(7, 0);
    rd_reg(7, d);
    check_eq("ufcnt_clear", d, 0);
    underflow_sticky = 1;
    wr_reg(1, 32'h4);
    check_eq("clr_uf_set", clear_underflow_sticky, 1);
    repeat (3) step();
    check_eq("clr_uf_hold", clear_underflow_sticky, 1);
    underflow_sticky = 0;
    step();
    check_eq("clr_uf_drop", clear_underflow_sticky, 0);

    // Randomized register traffic
    for (int n = 0; n < 500; n++) begin
      int sel;
      usedw = UW'($urandom_range(107, 93));
      if ($urandom_range(7, 0) == 0) genlocked = ~genlocked;
      if ($urandom_range(7, 0) == 0) underflow_sticky = ~underflow_sticky;
      enable_resync = 1'($urandom);
      mode_change = ($urandom_range(5, 0) == 0);
      mode_match = NM'($urandom);
      mode_write_ack = ($urandom_range(15, 0) == 0);
      av_write = 0; av_read = 0;
      if ($urandom_range(3, 0) == 0) begin
        sel = $urandom_range(4, 0);
        av_write = 1;
        case (sel)
          0: av_address = 8'd0;
          1: av_address = 8'd1;
          2: av_address = 8'd2;
          3: av_address = 8'd6;
          default: av_address = 8'd7;
        endcase
        av_writedata = (sel == 3) ? 32'($urandom_range(105, 95)) : $urandom;
      end else if ($urandom_range(2, 0) == 0) begin
        av_read = 1;
        av_address = 8'($urandom_range(9, 0));
      end
      step();
    end
    av_write = 0; av_read = 0; mode_change = 0; mode_write_ack = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
